stream_pattern_source: RTL



---
 rtl/stream_pattern_pkg.sv | 23 ++
 rtl/stream_pattern_source.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/stream_pattern_pkg.sv
// Shared types and default widths for the stream pattern source.
package stream_pattern_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned GAP_W  = 4;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      GAP,
      DONE
   } state_e;

   // One burst request at default widths.
   typedef struct packed {
      logic [CNT_W-1:0]  num_beats;
      logic [DATA_W-1:0] base;
      logic [DATA_W-1:0] stride;
      logic [GAP_W-1:0]  gap;
   } cfg_t;

endpackage

// File: rtl/stream_pattern_source.sv
// Valid/ready stream source emitting base, base+stride, ... for a programmed
// number of beats, with a fixed idle gap after every accepted beat.
module stream_pattern_source
   import stream_pattern_pkg::*;
#(
   parameter int unsigned DataWidth = DATA_W,
   parameter int unsigned CntWidth  = CNT_W,
   parameter int unsigned GapWidth  = GAP_W
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [CntWidth-1:0]  num_beats_i,
   input  logic [DataWidth-1:0] base_i,
   input  logic [DataWidth-1:0] stride_i,
   input  logic [GapWidth-1:0]  gap_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [DataWidth-1:0] data_o,
   output logic                 last_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [CntWidth-1:0]  beats_sent_o
);

   state_e               state_q, state_d;
   logic                 valid_q, valid_d;
   logic [DataWidth-1:0] data_q, data_d;
   logic                 last_q, last_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [CntWidth-1:0]  beats_q, beats_d;
   logic [CntWidth-1:0]  num_q, num_d;
   logic [DataWidth-1:0] stride_q, stride_d;
   logic [GapWidth-1:0]  gap_q, gap_d;
   logic [GapWidth-1:0]  gap_cnt_q, gap_cnt_d;

   logic [CntWidth-1:0]  beats_inc;
   logic [CntWidth-1:0]  num_minus1;

   // beats_q never exceeds num_q-1 while sending, so the increment cannot wrap.
   assign beats_inc  = beats_q + CntWidth'(1);
   assign num_minus1 = num_q - CntWidth'(1);

   // Next-state, counters and registered output values.
   always_comb begin
      state_d   = state_q;
      valid_d   = valid_q;
      data_d    = data_q;
      last_d    = last_q;
      done_d    = 1'b0;
      beats_d   = beats_q;
      num_d     = num_q;
      stride_d  = stride_q;
      gap_d     = gap_q;
      gap_cnt_d = gap_cnt_q;

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               num_d    = num_beats_i;
               stride_d = stride_i;
               gap_d    = gap_i;
               data_d   = base_i;
               beats_d  = '0;
               if (num_beats_i == '0) begin
                  state_d = DONE;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
               end else begin
                  state_d = SEND;
                  valid_d = 1'b1;
                  last_d  = (num_beats_i == CntWidth'(1));
               end
            end
         end
         SEND: begin
            if (valid_q && ready_i) begin
               beats_d = beats_inc;
               data_d  = data_q + stride_q;
               if (beats_inc == num_q) begin
                  state_d = DONE;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
               end else if (gap_q == '0) begin
                  valid_d = 1'b1;
                  last_d  = (beats_inc == num_minus1);
               end else begin
                  state_d   = GAP;
                  valid_d   = 1'b0;
                  last_d    = 1'b0;
                  gap_cnt_d = gap_q;
               end
            end
         end
         GAP: begin
            if (gap_cnt_q <= GapWidth'(1)) begin
               state_d = SEND;
               valid_d = 1'b1;
               last_d  = (beats_q == num_minus1);
            end else begin
               gap_cnt_d = gap_cnt_q - GapWidth'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         valid_q   <= 1'b0;
         data_q    <= '0;
         last_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         beats_q   <= '0;
         num_q     <= '0;
         stride_q  <= '0;
         gap_q     <= '0;
         gap_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         data_q    <= data_d;
         last_q    <= last_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         beats_q   <= beats_d;
         num_q     <= num_d;
         stride_q  <= stride_d;
         gap_q     <= gap_d;
         gap_cnt_q <= gap_cnt_d;
      end
   end

   assign valid_o      = valid_q;
   assign data_o       = data_q;
   assign last_o       = last_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign beats_sent_o = beats_q;

endmodule
